latch_sample_reader: RTL and testbench
======================================

LATCH_SAMPLE_READER -- requirements
Module: latch_sample_reader

Interface
REQ-001 Parameter WIDTH, default 8, sets the data bus width.
REQ-002 Parameter SETTLE, default 2, sets the post-close settle cycles; legal range 1..15.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 D  input  WIDTH  asynchronous data from an external gated D latch Q bus.
REQ-006 G  input  1  asynchronous gate of that latch; high = transparent, low = holding.
REQ-007 out_data  output  WIDTH  last captured latch value.
REQ-008 out_valid  output  1  out_data holds an unconsumed sample.
REQ-009 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-010 overflow  output  1  sticky flag: a sample was dropped.
REQ-011 capture_count  output  8  number of accepted samples, modulo 256.
REQ-012 busy  output  1  high while the FSM is in OPEN or SETTLE.

Function
REQ-013 G and every D bit SHALL each pass through a 2-flop synchronizer; g_s and d_s denote the second-stage outputs.
REQ-014 The FSM SHALL have states IDLE, OPEN and SETTLE, plus a settle counter cnt of 4 bits.
REQ-015 IDLE: g_s=1 -> OPEN; otherwise stay.
REQ-016 OPEN: g_s=0 -> SETTLE with cnt=0; otherwise stay.
REQ-017 SETTLE: g_s=1 -> OPEN with no capture (abort); else if cnt=SETTLE-1 -> capture event then IDLE; else cnt increments.
REQ-018 A capture event SHALL load out_data<=d_s, set out_valid=1, and increment capture_count, all on the same edge, if the slot is free.
REQ-019 The slot SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1 on that same cycle (pop and push together; out_valid stays 1 with new data).
REQ-020 If the slot is not free, a capture event SHALL leave out_data and capture_count unchanged and set overflow=1.
REQ-021 overflow SHALL stay 1 until rst.
REQ-022 out_valid SHALL clear on an edge where out_valid=1, out_ready=1 and no capture event occurs.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 Latency: counting the first edge that samples G=0 as edge 1, out_valid SHALL rise on edge SETTLE+3.
REQ-025 capture_count SHALL wrap from 255 to 0 without any flag.
REQ-026 busy SHALL be combinational from state: 1 in OPEN or SETTLE.
REQ-027 A G pulse shorter than 2 clock periods MAY be missed; this is not an error.
REQ-028 out_data SHALL change only on a capture event or reset.

Reset
REQ-029 When rst=1 at an edge, the following SHALL be set: state=IDLE, cnt=0, both synchronizer stages=0, out_data=0, out_valid=0, overflow=0, capture_count=0.
REQ-030 rst SHALL take priority over every other event, including a capture in progress, which is discarded.
REQ-031 The first capture after reset SHALL require a fresh G high-then-low sequence observed after reset.

Verification
REQ-032 Single capture: SETTLE=2, D=8'hA5, G high 4 cycles then low, out_ready=0 -> out_valid=1 on edge 5 after G low, out_data=A5, capture_count=1, overflow=0.
REQ-033 Overflow: after REQ-032, second pulse with D=8'h3C and out_ready held 0 -> out_data stays A5, capture_count=1, overflow=1.
REQ-034 Simultaneous pop and push: out_valid=1 holding 8'h11, new capture of 8'h22 on the same cycle as out_ready=1 -> out_valid stays 1, out_data=22, overflow=0, capture_count increments.
REQ-035 Abort: G falls, then rises again during SETTLE -> state returns to OPEN, no capture; the later final fall captures the D value then present.
REQ-036 Wrap: 256 accepted captures with out_ready=1 -> capture_count reads 0 after the 256th.
REQ-037 Mid-operation reset: rst pulsed during SETTLE -> next edge gives IDLE, out_valid=0, capture_count=0, and no capture follows unless G pulses again.

Source files
------------

// File: rtl/latch_sample_reader.sv
// Samples the Q bus of an external gated D latch once its gate has closed and settled,
// handing each sample to a consumer through a one-entry valid/ready slot.
module latch_sample_reader #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             G,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [7:0]       capture_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic             r_g_s1;
  logic             r_g_s2;
  logic [WIDTH-1:0] r_d_s1;
  logic [WIDTH-1:0] r_d_s2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             w_capture;
  logic             w_slot_free;

  // Two-flop synchronizers for the latch gate and every data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_s1 <= 1'b0;
      r_g_s2 <= 1'b0;
      r_d_s1 <= '0;
      r_d_s2 <= '0;
    end else begin
      r_g_s1 <= G;
      r_g_s2 <= r_g_s1;
      r_d_s1 <= D;
      r_d_s2 <= r_d_s1;
    end
  end

  // FSM state and settle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; a gate reopening during settle aborts the capture
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_g_s2) begin
          w_state_nxt = ST_OPEN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (!r_g_s2) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_SETTLE: begin
        if (r_g_s2) begin
          w_state_nxt = ST_OPEN;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Busy decodes straight from the current state
  always_comb begin
    if (r_state == ST_OPEN || r_state == ST_SETTLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // The slot accepts a new sample if empty or being popped this same cycle
  always_comb begin
    w_slot_free = !out_valid || out_ready;
  end

  // Output slot: push, pop, and sticky overflow on a dropped sample
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      overflow      <= 1'b0;
      capture_count <= 8'd0;
    end else if (w_capture && w_slot_free) begin
      out_data      <= r_d_s2;
      out_valid     <= 1'b1;
      capture_count <= capture_count + 8'd1;
    end else if (w_capture) begin
      overflow <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_latch_sample_reader.sv
// Directed bench for latch_sample_reader: capture latency, overflow, pop+push,
// abort, counter wrap and mid-operation reset.
module tb_latch_sample_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D;
  logic       G;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [7:0] capture_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  latch_sample_reader #(.WIDTH(8), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .D(D), .G(G),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .capture_count(capture_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Gate high for hi cycles, then low; returns right after G is lowered
  task automatic open_gate(input int hi);
    G = 1'b1;
    tick(hi);
    G = 1'b0;
  endtask

  initial begin
    rst = 1'b1; D = 8'h00; G = 1'b0; out_ready = 1'b0;
    tick(2);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", capture_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(1);

    // Single capture: valid rises on edge 5 after G falls
    D = 8'hA5;
    G = 1'b1;
    tick(4);
    check("open_busy", busy, 1);
    G = 1'b0;
    tick(4);
    check("lat_edge4_valid", out_valid, 0);
    tick(1);
    check("lat_edge5_valid", out_valid, 1);
    check("cap1_data", out_data, 8'hA5);
    check("cap1_count", capture_count, 1);
    check("cap1_ovf", overflow, 0);
    check("cap1_busy", busy, 0);

    // Overflow: slot still full
    D = 8'h3C;
    open_gate(4);
    tick(6);
    check("ovf_data", out_data, 8'hA5);
    check("ovf_count", capture_count, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(1);
    check("pop_valid", out_valid, 0);
    check("ovf_sticky", overflow, 1);
    out_ready = 1'b0;

    rst = 1'b1;
    tick(1);
    check("rst2_ovf", overflow, 0);
    check("rst2_count", capture_count, 0);
    rst = 1'b0;

    // Ready while empty has no effect
    out_ready = 1'b1;
    tick(2);
    check("ready_empty_valid", out_valid, 0);
    out_ready = 1'b0;

    // Pop and push on the same edge
    D = 8'h11;
    open_gate(4);
    tick(5);
    check("pp_first_data", out_data, 8'h11);
    D = 8'h22;
    open_gate(4);
    tick(4);
    check("pp_pre_data", out_data, 8'h11);
    out_ready = 1'b1;
    tick(1);
    check("pp_valid", out_valid, 1);
    check("pp_data", out_data, 8'h22);
    check("pp_ovf", overflow, 0);
    check("pp_count", capture_count, 2);
    tick(1);
    check("pp_pop_valid", out_valid, 0);
    out_ready = 1'b0;

    // Abort: gate reopens while settling, capture later with new D
    D = 8'h44;
    open_gate(4);
    tick(2);
    G = 1'b1;
    tick(3);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 1);
    check("abort_count", capture_count, 2);
    D = 8'h66;
    tick(3);
    G = 1'b0;
    tick(5);
    check("abort_cap_valid", out_valid, 1);
    check("abort_cap_data", out_data, 8'h66);
    check("abort_cap_count", capture_count, 3);

    // Wrap: 256 accepted captures from reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      D = 8'(k);
      open_gate(3);
      tick(5);
      if (k == 255) begin
        check("wrap_255_count", capture_count, 255);
        check("wrap_255_data", out_data, 8'hFF);
      end
    end
    check("wrap_256_count", capture_count, 0);
    check("wrap_256_data", out_data, 8'h00);
    check("wrap_ovf", overflow, 0);
    tick(1);
    out_ready = 1'b0;

    // Mid-operation reset during settle
    D = 8'h77;
    open_gate(3);
    tick(3);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", capture_count, 0);
    rst = 1'b0;
    tick(10);
    check("mid_nocap_valid", out_valid, 0);
    check("mid_nocap_count", capture_count, 0);
    D = 8'h88;
    open_gate(3);
    tick(5);
    check("mid_fresh_valid", out_valid, 1);
    check("mid_fresh_data", out_data, 8'h88);
    check("mid_fresh_count", capture_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
